fp_mul_seq: RTL and testbench

Sequential IEEE-754 single-precision mantissa/exponent multiply stage. It is the producer side of the normalize interface: it accepts two packed operands and performs an iterative shift-add 24×24 mantissa multiply. It presents the raw 48-bit product, biased 9-bit exponent and sign in the layout the normalize stage consumes. Valid/ready handshakes on both sides let it sit between the operand register stage and normalize.

---
 rtl/fp_mul_seq_pkg.sv | 27 ++
 rtl/fp_mul_seq_if.sv | 23 ++
 rtl/fp_mul_seq_mant_shift_add.sv | 42 ++++
 rtl/fp_mul_seq.sv | 160 ++++++++++++++++
 tb/tb_fp_mul_seq.sv | 162 ++++++++++++++++
 5 files changed

// File: rtl/fp_mul_seq_pkg.sv
// Shared types and constants for the fp_mul_seq multiply stage.
// FP_MUL_RADIX4_EN selects radix-4 iteration (12 cycles) instead of radix-2 (24 cycles).
package fp_pkg;

  localparam int BIAS   = 127;
  localparam int EXP_W  = 8;
  localparam int MANT_W = 24;
  localparam int PROD_W = 51;
  localparam int EXPI_W = 10;
  localparam int ACC_W  = 2 * MANT_W;
  localparam int CNT_W  = 5;

`ifdef FP_MUL_RADIX4_EN
  localparam bit RADIX4_EN = 1'b1;
  localparam int ITER_N    = 12;
`else
  localparam bit RADIX4_EN = 1'b0;
  localparam int ITER_N    = 24;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/fp_mul_seq_if.sv
// Operand/result handshake bundle between the operand stage, fp_mul_seq and normalize.
interface fp_mul_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [50:0] product_o;
  logic [8:0]  exponent_o;
  logic        sign_o;
  logic        zero_o;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, product_o, exponent_o, sign_o, zero_o
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, product_o, exponent_o, sign_o, zero_o
  );
endinterface

// File: rtl/fp_mul_seq_mant_shift_add.sv
// One shift-add mantissa multiply iteration; RADIX4 consumes two multiplier bits per step.
module mant_shift_add #(
  parameter bit RADIX4 = 1'b0
) (
  input  logic [47:0] acc_i,
  input  logic [47:0] mcand_i,
  input  logic [47:0] mcand3_i,
  input  logic [23:0] mplier_i,
  output logic [47:0] acc_o,
  output logic [47:0] mcand_o,
  output logic [47:0] mcand3_o,
  output logic [23:0] mplier_o
);

  generate
    if (RADIX4) begin : g_r4
      logic [47:0] addend;

      always_comb begin
        addend = '0;
        case (mplier_i[1:0])
          2'd0:    addend = '0;
          2'd1:    addend = mcand_i;
          2'd2:    addend = mcand_i << 1;
          default: addend = mcand3_i;
        endcase
      end

      assign acc_o    = acc_i + addend;
      assign mcand_o  = mcand_i << 2;
      assign mcand3_o = mcand3_i << 2;
      assign mplier_o = mplier_i >> 2;
    end else begin : g_r2
      // 3M is not needed here but is kept moving so both builds share one register set
      assign acc_o    = acc_i + (mplier_i[0] ? mcand_i : 48'd0);
      assign mcand_o  = mcand_i << 1;
      assign mcand3_o = mcand3_i << 1;
      assign mplier_o = mplier_i >> 1;
    end
  endgenerate

endmodule

// File: rtl/fp_mul_seq.sv
// Sequential single-precision mantissa/exponent multiply feeding the normalize stage.
// Define FP_MUL_RADIX4_EN for the radix-4 (12-iteration) build; default is radix-2.
module fp_mul_seq
  import fp_pkg::*;
#(
  parameter int BIAS    = 127,
  parameter int EXP_MAX = 511
) (
  input  logic          clk,
  input  logic          reset,
  fp_mul_seq_if.slave   bus
);

  function automatic logic [8:0] sat_exp(input logic [EXP_W-1:0] ea, input logic [EXP_W-1:0] eb);
    logic signed [EXPI_W-1:0] s;
    s = $signed({2'b00, ea}) + $signed({2'b00, eb}) - $signed(EXPI_W'(BIAS));
    if (s < 0)
      sat_exp = '0;
    else if (s > $signed(EXPI_W'(EXP_MAX)))
      sat_exp = 9'(EXP_MAX);
    else
      sat_exp = 9'(s);
  endfunction

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ACC_W-1:0]   acc_q, acc_d, mcand_q, mcand_d, mcand3_q, mcand3_d;
  logic [MANT_W-1:0]  mplier_q, mplier_d;
  logic [8:0]         exp_q, exp_d;
  logic               sign_q, sign_d, zero_q, zero_d;
  logic [ACC_W-1:0]   prod_q, prod_d;
  logic [8:0]         expo_q, expo_d;
  logic               sgn_o_q, sgn_o_d, zero_o_q, zero_o_d;
  logic               out_valid_q, out_valid_d, in_ready_q, in_ready_d;

  logic [ACC_W-1:0]   acc_nx, mcand_nx, mcand3_nx;
  logic [MANT_W-1:0]  mplier_nx;

  logic [EXP_W-1:0]   ea, eb;
  logic [MANT_W-1:0]  mant_a, mant_b;
  logic               za, zb;

  // Unpack: hidden bit is set for any non-zero exponent, so denormals keep hidden=0
  assign ea     = bus.a[30:23];
  assign eb     = bus.b[30:23];
  assign mant_a = {(ea != '0), bus.a[22:0]};
  assign mant_b = {(eb != '0), bus.b[22:0]};
  assign za     = (ea == '0) && (bus.a[22:0] == '0);
  assign zb     = (eb == '0) && (bus.b[22:0] == '0);

  mant_shift_add #(.RADIX4(RADIX4_EN)) u_msa (
    .acc_i    (acc_q),
    .mcand_i  (mcand_q),
    .mcand3_i (mcand3_q),
    .mplier_i (mplier_q),
    .acc_o    (acc_nx),
    .mcand_o  (mcand_nx),
    .mcand3_o (mcand3_nx),
    .mplier_o (mplier_nx)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    mcand_d     = mcand_q;
    mcand3_d    = mcand3_q;
    mplier_d    = mplier_q;
    exp_d       = exp_q;
    sign_d      = sign_q;
    zero_d      = zero_q;
    prod_d      = prod_q;
    expo_d      = expo_q;
    sgn_o_d     = sgn_o_q;
    zero_o_d    = zero_o_q;
    out_valid_d = out_valid_q;

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          acc_d    = '0;
          mcand_d  = ACC_W'(mant_a);
          mcand3_d = ACC_W'(mant_a) + (ACC_W'(mant_a) << 1);
          mplier_d = mant_b;
          exp_d    = sat_exp(ea, eb);
          sign_d   = bus.a[31] ^ bus.b[31];
          zero_d   = za | zb;
          // A zero operand spends a single cycle in MUL so DONE lands on the next edge
          cnt_d    = (za | zb) ? CNT_W'(1) : CNT_W'(ITER_N);
          state_d  = MUL;
        end
      end
      MUL: begin
        acc_d    = acc_nx;
        mcand_d  = mcand_nx;
        mcand3_d = mcand3_nx;
        mplier_d = mplier_nx;
        cnt_d    = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d     = DONE;
          prod_d      = zero_q ? '0 : acc_nx;
          expo_d      = zero_q ? '0 : exp_q;
          sgn_o_d     = sign_q;
          zero_o_d    = zero_q;
          out_valid_d = 1'b1;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    in_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      prod_q      <= '0;
      expo_q      <= '0;
      sgn_o_q     <= 1'b0;
      zero_o_q    <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      prod_q      <= prod_d;
      expo_q      <= expo_d;
      sgn_o_q     <= sgn_o_d;
      zero_o_q    <= zero_o_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  // Working datapath registers are always reloaded at acceptance, so they carry no reset
  always_ff @(posedge clk) begin
    acc_q    <= acc_d;
    mcand_q  <= mcand_d;
    mcand3_q <= mcand3_d;
    mplier_q <= mplier_d;
    exp_q    <= exp_d;
    sign_q   <= sign_d;
    zero_q   <= zero_d;
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.product_o  = {3'b000, prod_q};
  assign bus.exponent_o = expo_q;
  assign bus.sign_o     = sgn_o_q;
  assign bus.zero_o     = zero_o_q;

endmodule

// File: tb/tb_fp_mul_seq.sv
// Directed-vector bench for fp_mul_seq: latency, results, backpressure and mid-operation reset.
module tb_fp_mul_seq;
  import fp_pkg::*;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;

  fp_mul_seq_if bus ();

  fp_mul_seq #(.BIAS(127), .EXP_MAX(511)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_vec++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Accept a/b, measure edges until out_valid, check results, then release with out_ready.
  task automatic run_vec(input string tag, input logic [31:0] av, input logic [31:0] bv,
                         input logic [47:0] prod, input logic [8:0] expo,
                         input logic sgn, input logic zro, input int lat);
    int n;
    @(negedge clk);
    bus.a        = av;
    bus.b        = bv;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.a        = 32'hDEAD_BEEF;
    bus.b        = 32'h1234_5678;
    n = 0;
    while (!bus.out_valid && n < 100) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    chk({tag, ".latency"}, 64'(n), 64'(lat));
    chk({tag, ".product"}, 64'(bus.product_o), 64'({3'b000, prod}));
    chk({tag, ".exponent"}, 64'(bus.exponent_o), 64'(expo));
    chk({tag, ".sign"}, 64'(bus.sign_o), 64'(sgn));
    chk({tag, ".zero"}, 64'(bus.zero_o), 64'(zro));
    chk({tag, ".in_ready_busy"}, 64'(bus.in_ready), 64'd0);
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk({tag, ".out_valid_drop"}, 64'(bus.out_valid), 64'd0);
    chk({tag, ".in_ready_idle"}, 64'(bus.in_ready), 64'd1);
  endtask

  initial begin
    logic [50:0] hold_p;
    logic [8:0]  hold_e;
    n_vec = 0;
    n_err = 0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    reset         = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst.in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst.out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst.product", 64'(bus.product_o), 64'd0);
    chk("rst.exponent", 64'(bus.exponent_o), 64'd0);
    chk("rst.sign_zero", 64'({bus.sign_o, bus.zero_o}), 64'd0);
    reset = 1'b1;

    run_vec("one_x_one", 32'h3F80_0000, 32'h3F80_0000, 48'h4000_0000_0000, 9'd127, 1'b0, 1'b0, ITER_N);
    run_vec("two_x_three", 32'h4000_0000, 32'h4040_0000, 48'h6000_0000_0000, 9'd129, 1'b0, 1'b0, ITER_N);
    run_vec("neg_1p5_sq", 32'hBFC0_0000, 32'h3FC0_0000, 48'h9000_0000_0000, 9'd127, 1'b1, 1'b0, ITER_N);
    run_vec("zero_x_pi", 32'h0000_0000, 32'h4049_0FDB, 48'h0, 9'd0, 1'b0, 1'b1, 1);
    run_vec("negzero_x_pi", 32'h8000_0000, 32'h4049_0FDB, 48'h0, 9'd0, 1'b1, 1'b1, 1);
    run_vec("exp_underflow", 32'h0080_0000, 32'h0080_0000, 48'h4000_0000_0000, 9'd0, 1'b0, 1'b0, ITER_N);
    run_vec("exp_high", 32'h7F00_0000, 32'h7F00_0000, 48'h4000_0000_0000, 9'd381, 1'b0, 1'b0, ITER_N);
    // all-ones mantissas: 0xFFFFFF^2 = 0xFFFFFE000001
    run_vec("max_mant", 32'h3FFF_FFFF, 32'hBFFF_FFFF, 48'hFFFF_FE00_0001, 9'd127, 1'b1, 1'b0, ITER_N);

    // Backpressure: hold DONE for 5 cycles with stray in_valid pulses
    @(negedge clk);
    bus.a = 32'h4000_0000;
    bus.b = 32'h4040_0000;
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (ITER_N) @(posedge clk);
    @(negedge clk);
    chk("bp.out_valid", 64'(bus.out_valid), 64'd1);
    hold_p = bus.product_o;
    hold_e = bus.exponent_o;
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = i[0];
      bus.a = 32'h3F80_0000;
      bus.b = 32'h3F80_0000;
      @(posedge clk);
      @(negedge clk);
      chk("bp.hold_valid", 64'(bus.out_valid), 64'd1);
      chk("bp.hold_prod", 64'(bus.product_o), 64'h6000_0000_0000);
      chk("bp.hold_exp", 64'(bus.exponent_o), 64'd129);
      chk("bp.in_ready", 64'(bus.in_ready), 64'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("bp.released", 64'({bus.out_valid, bus.in_ready}), 64'd1);
    chk("bp.prod_kept", 64'(hold_p), 64'h6000_0000_0000);
    chk("bp.exp_kept", 64'(hold_e), 64'd129);

    // Reset in the middle of the iterations
    @(negedge clk);
    bus.a = 32'h7F00_0000;
    bus.b = 32'hBFC0_0000;
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midrst.product", 64'(bus.product_o), 64'd0);
    chk("midrst.exponent", 64'(bus.exponent_o), 64'd0);
    chk("midrst.flags", 64'({bus.out_valid, bus.sign_o, bus.zero_o}), 64'd0);
    chk("midrst.in_ready", 64'(bus.in_ready), 64'd1);
    @(negedge clk);
    reset = 1'b1;
    repeat (ITER_N + 2) begin
      @(negedge clk);
      chk("midrst.no_pulse", 64'(bus.out_valid), 64'd0);
    end
    chk("midrst.in_ready_after", 64'(bus.in_ready), 64'd1);
    run_vec("after_rst", 32'hBFC0_0000, 32'h3FC0_0000, 48'h9000_0000_0000, 9'd127, 1'b1, 1'b0, ITER_N);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
